// File: rtl/cmp_sweep_driver_pkg.sv
// cmp_pkg: definitions shared by the comparator sweep engine and any other
// comparator-family block.
//   state_t    : 2-bit sweep FSM encoding (IDLE=0, APPLY=1, CHECK=2, FINISH=3)
//   CMP_MAX_W  : widest operand cmp_expect accepts; narrower operands are
//                zero-extended by the caller, which keeps the compare unsigned
//   cmp_expect : reference result packed as {eq, gt, lt}
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int CMP_MAX_W = 32;

  function automatic logic [2:0] cmp_expect(input logic [CMP_MAX_W-1:0] a,
                                            input logic [CMP_MAX_W-1:0] b);
    return {a == b, a > b, a < b};
  endfunction

endpackage

// File: rtl/cmp_sweep_driver_if.sv
// Operand/response bus between the sweep engine and the comparator under test.
//   cmp_a, cmp_b          : operands, driven by the engine (master)
//   cmp_eq, cmp_gt, cmp_lt: comparator response, driven by the comparator (slave)
interface cmp_sweep_driver_if #(
  parameter int WIDTH = 3
);

  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             cmp_eq;
  logic             cmp_gt;
  logic             cmp_lt;

  modport master (
    output cmp_a,
    output cmp_b,
    input  cmp_eq,
    input  cmp_gt,
    input  cmp_lt
  );

  modport slave (
    input  cmp_a,
    input  cmp_b,
    output cmp_eq,
    output cmp_gt,
    output cmp_lt
  );

endinterface

// File: rtl/cmp_sweep_driver_golden.sv
// cmp_golden: parameterised combinational reference magnitude comparator.
//   a, b       in  WIDTH : unsigned operands
//   eq, gt, lt out 1     : a==b, a>b, a<b
module cmp_golden
  import cmp_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  logic [CMP_MAX_W-1:0] a_ext;
  logic [CMP_MAX_W-1:0] b_ext;
  logic [2:0]           res;

  assign a_ext = CMP_MAX_W'(a);
  assign b_ext = CMP_MAX_W'(b);
  assign res   = cmp_expect(a_ext, b_ext);

  assign eq = res[2];
  assign gt = res[1];
  assign lt = res[0];

endmodule

// File: rtl/cmp_sweep_driver.sv
// cmp_sweep_driver: in-system self-test engine for a WIDTH-bit magnitude
// comparator. Sweeps every (a, b) pair with a in the outer loop, holds each
// vector for SETTLE cycles, samples the response on the following cycle and
// compares it with cmp_golden.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   start       : run request, honoured in IDLE or FINISH only
//   bus         : master side of cmp_sweep_driver_if (operands out, response in)
//   busy        : sweep in progress
//   done, pass  : sweep complete / complete with zero mismatches
//   err_count   : number of mismatching vectors
//   fail_valid, fail_a, fail_b : first mismatching vector
module cmp_sweep_driver
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  cmp_sweep_driver_if.master bus,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);

  localparam int             EW       = 2 * WIDTH + 1;
  localparam int             CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] OP_MAX = '1;
  localparam logic [WIDTH-1:0] OP_ONE = WIDTH'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             exp_eq;
  logic             exp_gt;
  logic             exp_lt;
  logic             mismatch;
  logic             last_vec;
  logic             launch;
  logic             check_exit;
  logic [EW-1:0]    err_nxt;

  cmp_golden #(
    .WIDTH(WIDTH)
  ) u_golden (
    .a  (a_q),
    .b  (b_q),
    .eq (exp_eq),
    .gt (exp_gt),
    .lt (exp_lt)
  );

  assign bus.cmp_a = a_q;
  assign bus.cmp_b = b_q;

  // Non-one-hot responses fall out naturally as mismatches: the golden value
  // is always one-hot, so any extra or missing bit differs from it.
  assign mismatch = {bus.cmp_eq, bus.cmp_gt, bus.cmp_lt} != {exp_eq, exp_gt, exp_lt};
  assign last_vec = (a_q == OP_MAX) && (b_q == OP_MAX);
  assign err_nxt  = err_count + EW'(mismatch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    launch     = 1'b0;
    check_exit = 1'b0;
    case (state)
      IDLE, FINISH: begin
        if (start) begin
          state_nxt = APPLY;
          launch    = 1'b1;
        end
      end
      APPLY: begin
        if (cnt == CNT_LAST) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        check_exit = 1'b1;
        state_nxt  = last_vec ? FINISH : APPLY;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand walk, settle counter and result bookkeeping. The response is only
  // ever consumed here, so no output has a combinational path from cmp_*.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
    end else if (launch) begin
      a_q        <= '0;
      b_q        <= '0;
      cnt        <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
    end else begin
      if (state == APPLY) begin
        cnt <= cnt + CNT_ONE;
      end
      if (check_exit) begin
        cnt       <= '0;
        err_count <= err_nxt;
        if (mismatch && !fail_valid) begin
          fail_valid <= 1'b1;
          fail_a     <= a_q;
          fail_b     <= b_q;
        end
        // On the last vector the operands stay put so (max, max) remains
        // visible while FINISH holds the verdict.
        if (last_vec) begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_nxt == '0);
        end else if (b_q == OP_MAX) begin
          b_q <= '0;
          a_q <= a_q + OP_ONE;
        end else begin
          b_q <= b_q + OP_ONE;
        end
      end
    end
  end

endmodule

// File: doc/cmp_sweep_driver.md
# cmp_sweep_driver

Synthesizable stimulus/check engine that drives the operand side of a WIDTH-bit magnitude comparator and checks its `eq`/`gt`/`lt` response.
- Sweeps all 2^(2·WIDTH) operand pairs: `a` in the outer loop, `b` in the inner loop.
- Waits a programmable settle time per vector, then compares the response against a golden model.
- Counts mismatches and reports pass/fail.
- Sits beside the comparator as its initiator: in-system self-test for the comparator family.

## Interface
- `WIDTH`, default 3: operand width.
- `SETTLE`, default 1: cycles operands are held before sampling; legal range ≥1.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle run request; honoured only in IDLE or FINISH.
- `cmp_a`  out  WIDTH: operand A to the comparator.
- `cmp_b`  out  WIDTH: operand B to the comparator.
- `cmp_eq`  in  1: comparator result, A==B.
- `cmp_gt`  in  1: comparator result, A>B.
- `cmp_lt`  in  1: comparator result, A<B.
- `busy`  out  1: sweep in progress.
- `done`  out  1: sweep complete; held until next start or reset.
- `pass`  out  1: `done` and zero mismatches.
- `err_count`  out  2·WIDTH+1: mismatching vectors; holds up to 2^(2·WIDTH), no saturation needed.
- `fail_valid`  out  1: at least one mismatch captured.
- `fail_a`  out  WIDTH: A of first mismatching vector.
- `fail_b`  out  WIDTH: B of first mismatching vector.

## Operation
- FSM states: IDLE, APPLY, CHECK, FINISH.
- IDLE -> APPLY on `start`:
  - `cmp_a`=0, `cmp_b`=0, settle counter=0.
  - `err_count`, `fail_*`, `done`, `pass` cleared.
  - `busy`=1.
- APPLY: operands held; counter increments each cycle; -> CHECK after SETTLE cycles in APPLY.
- CHECK (one cycle, operands still held): sample `{cmp_eq,cmp_gt,cmp_lt}` at the exiting edge.
  - Expected value: `{a==b, a>b, a<b}`, unsigned.
  - Any bit differing is a mismatch: `err_count`+1.
  - First mismatch only: `fail_valid`=1 and `fail_a`/`fail_b` latched.
- Exit from CHECK:
  - `cmp_b` != max: `cmp_b`+1 -> APPLY.
  - `cmp_b` == max, `cmp_a` != max: `cmp_b`=0, `cmp_a`+1 -> APPLY.
  - Both at max -> FINISH.
- FINISH: `busy`=0, `done`=1, `pass`=(`err_count`==0). Operands hold the last vector.
- `start` in FINISH restarts exactly as from IDLE. `start` in APPLY/CHECK is ignored.
- Non-one-hot responses (e.g. eq and gt both high) are mismatches. No separate flag.

## Timing
- Reset (async assert, sync release): state=IDLE. All outputs 0: `cmp_a`, `cmp_b`, `busy`, `done`, `pass`, `err_count`, `fail_valid`, `fail_a`, `fail_b`.
- Reset mid-sweep: immediate abort to the reset values above. No partial result is retained.
- Let edge E0 be the edge that samples `start`. From E0:
  - `busy`=1 and the operands are (0,0).
  - Each vector occupies exactly SETTLE+1 cycles.
  - The response is sampled SETTLE+1 edges after the operands change.
  - `done` rises and `busy` falls at E0 + 2^(2·WIDTH)·(SETTLE+1).
- `err_count`/`fail_*` update on the CHECK exit edge. `pass` becomes valid on the same edge as `done`.
- All outputs are registered. No combinational path from `cmp_*` inputs to any output.

## Structure
- Shared package `cmp_pkg` holds:
  - FSM state encodings (2-bit, IDLE=0, APPLY=1, CHECK=2, FINISH=3).
  - The expected-result function `cmp_expect(a,b)` returning `{eq,gt,lt}`.
- One sub-module is natural: `cmp_golden`, a parameterised combinational reference comparator (WIDTH) instantiated for the expected value. It is reusable by other comparator blocks.
- Top contains the FSM, operand counters, settle counter and error bookkeeping.

## Test plan
- Golden loopback (WIDTH=3, SETTLE=1): the correct comparator drives the `cmp_*` inputs; pulse `start`.
  - Required: `done`=1, `busy`=0 exactly 128 cycles after E0.
  - `pass`=1, `err_count`=0, `fail_valid`=0.
- `cmp_eq` stuck at 0:
  - Required: `err_count`=8, `pass`=0.
  - `fail_valid`=1, `fail_a`=0, `fail_b`=0.
- `cmp_gt`/`cmp_lt` swapped:
  - Required: `err_count`=56.
  - First failure `fail_a`=0, `fail_b`=1.
- SETTLE=3 golden loopback:
  - Operands change every 4 cycles.
  - `done` at E0+256.
  - The (7,7) vector is visible on `cmp_a`/`cmp_b` in the final 4 cycles.
- Protocol edges:
  - `start` pulsed mid-sweep: no effect; same completion cycle.
  - `start` in FINISH: counts cleared, sweep reruns.
  - `rst_n` low at cycle 40: all outputs 0 immediately, state IDLE; no activity until the next `start`.
